// File: rtl/airlock_pkg.sv
// Shared definitions for the two-door airlock sequencer: state codes and
// watchdog timer width.
package airlock_pkg;

  localparam int TIMER_W = 8;

  typedef enum logic [2:0] {
    ST_PRESS      = 3'd0,
    ST_EVAC_WAIT  = 3'd1,
    ST_VAC        = 3'd2,
    ST_PRESS_WAIT = 3'd3,
    ST_FAULT      = 3'd4
  } state_e;

  // True for the two states where a countdown is running.
  function automatic logic is_wait(input state_e s);
    return (s == ST_EVAC_WAIT) || (s == ST_PRESS_WAIT);
  endfunction

endpackage

// File: rtl/airlock_timer.sv
// Watchdog counter for the wait states. Clear wins over enable; the count
// saturates at all-ones so a stuck wait can never wrap back to a small value.
module airlock_timer
  import airlock_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic hit_o
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT - 1);

  logic [TIMER_W-1:0] count_q, count_d;

  // Next count: clear on wait entry, otherwise count up while enabled.
  always_comb begin
    count_d = count_q;
    if (clear_i)
      count_d = '0;
    else if (enable_i && (count_q != '1))
      count_d = count_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  // Last permitted wait cycle: a done pulse here is still accepted.
  assign hit_o = (count_q == LAST);

endmodule

// File: rtl/airlock_ctrl.sv
// Two-door airlock sequencer. Unlocks only the door matching the chamber
// pressure, launches the pressurize/evacuate countdowns with one-cycle start
// pulses, and latches a fault on door-open or watchdog expiry mid-cycle.
module airlock_ctrl
  import airlock_pkg::*;
#(
  parameter int TIMEOUT = 16  // legal range 2..255
) (
  input  logic       clk,
  input  logic       rst_i,
  input  logic       inner_req_i,
  input  logic       outer_req_i,
  input  logic       inner_closed_i,
  input  logic       outer_closed_i,
  input  logic       press_done_i,
  input  logic       evac_done_i,
  input  logic       fault_clr_i,
  output logic       press_start_o,
  output logic       evac_start_o,
  output logic       inner_unlock_o,
  output logic       outer_unlock_o,
  output logic       busy_o,
  output logic       fault_o,
  output logic [2:0] state_o
);

  state_e state_q, state_d;
  logic   doors_closed;
  logic   tmr_hit;
  logic   press_start_q, evac_start_q, inner_unlock_q, outer_unlock_q;
  logic   busy_q, fault_q;

  assign doors_closed = inner_closed_i & outer_closed_i;

  // Timer restarts whenever a wait state is freshly entered (incl. from FAULT).
  airlock_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .rst_i    (rst_i),
    .clear_i  (is_wait(state_d) && (state_d != state_q)),
    .enable_i (is_wait(state_q)),
    .hit_o    (tmr_hit)
  );

  // Next-state logic; in wait states door-open beats done beats timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_PRESS:
        if (outer_req_i && doors_closed) state_d = ST_EVAC_WAIT;
      ST_EVAC_WAIT:
        if (!doors_closed)     state_d = ST_FAULT;
        else if (evac_done_i)  state_d = ST_VAC;
        else if (tmr_hit)      state_d = ST_FAULT;
      ST_VAC:
        if (inner_req_i && doors_closed) state_d = ST_PRESS_WAIT;
      ST_PRESS_WAIT:
        if (!doors_closed)     state_d = ST_FAULT;
        else if (press_done_i) state_d = ST_PRESS;
        else if (tmr_hit)      state_d = ST_FAULT;
      ST_FAULT:
        if (fault_clr_i && doors_closed) state_d = ST_PRESS_WAIT;
      default:
        state_d = ST_PRESS;
    endcase
  end

  // State and registered outputs, all decoded from the next state so they
  // line up with the state register.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q        <= ST_PRESS;
      press_start_q  <= 1'b0;
      evac_start_q   <= 1'b0;
      inner_unlock_q <= 1'b1;
      outer_unlock_q <= 1'b0;
      busy_q         <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      press_start_q  <= (state_d == ST_PRESS_WAIT) && (state_q != ST_PRESS_WAIT);
      evac_start_q   <= (state_d == ST_EVAC_WAIT)  && (state_q != ST_EVAC_WAIT);
      inner_unlock_q <= (state_d == ST_PRESS);
      outer_unlock_q <= (state_d == ST_VAC);
      busy_q         <= is_wait(state_d);
      fault_q        <= (state_d == ST_FAULT);
    end
  end

  assign press_start_o  = press_start_q;
  assign evac_start_o   = evac_start_q;
  assign inner_unlock_o = inner_unlock_q;
  assign outer_unlock_o = outer_unlock_q;
  assign busy_o         = busy_q;
  assign fault_o        = fault_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_airlock_ctrl.sv
// Directed bench for airlock_ctrl: a vector table for the main flow plus
// hand-written sequences for timeout, door-open, reset and boundary cases.
module tb_airlock_ctrl;

  localparam int TIMEOUT = 16;

  // Input bits: {rst, inner_req, outer_req, inner_closed, outer_closed,
  //              press_done, evac_done, fault_clr}
  localparam logic [7:0] I_IDLE    = 8'b0_0_0_1_1_0_0_0;
  localparam logic [7:0] I_RST     = 8'b1_0_0_1_1_0_0_0;
  localparam logic [7:0] I_OREQ    = 8'b0_0_1_1_1_0_0_0;
  localparam logic [7:0] I_IREQ    = 8'b0_1_0_1_1_0_0_0;
  localparam logic [7:0] I_IREQ_OO = 8'b0_1_0_1_0_0_0_0;
  localparam logic [7:0] I_PD      = 8'b0_0_0_1_1_1_0_0;
  localparam logic [7:0] I_ED      = 8'b0_0_0_1_1_0_1_0;
  localparam logic [7:0] I_ED_OO   = 8'b0_0_0_1_0_0_1_0;
  localparam logic [7:0] I_IC_OPEN = 8'b0_0_0_0_1_0_0_0;
  localparam logic [7:0] I_CLR     = 8'b0_0_0_1_1_0_0_1;
  localparam logic [7:0] I_CLR_OO  = 8'b0_0_0_1_0_0_0_1;
  localparam logic [7:0] I_RST_ED  = 8'b1_0_0_1_1_0_1_0;

  // Expected bits: {state[2:0], press_start, evac_start, inner_unlock,
  //                 outer_unlock, busy, fault}
  localparam logic [8:0] E_PRESS = {3'd0, 6'b001000};
  localparam logic [8:0] E_EVW_S = {3'd1, 6'b010010};
  localparam logic [8:0] E_EVW   = {3'd1, 6'b000010};
  localparam logic [8:0] E_VAC   = {3'd2, 6'b000100};
  localparam logic [8:0] E_PRW_S = {3'd3, 6'b100010};
  localparam logic [8:0] E_PRW   = {3'd3, 6'b000010};
  localparam logic [8:0] E_FLT   = {3'd4, 6'b000001};

  typedef struct packed {
    logic [7:0] in;
    logic [8:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_i, inner_req_i, outer_req_i, inner_closed_i, outer_closed_i;
  logic       press_done_i, evac_done_i, fault_clr_i;
  logic       press_start_o, evac_start_o, inner_unlock_o, outer_unlock_o;
  logic       busy_o, fault_o;
  logic [2:0] state_o;

  int n_vec = 0;
  int n_bad = 0;

  airlock_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst_i          (rst_i),
    .inner_req_i    (inner_req_i),
    .outer_req_i    (outer_req_i),
    .inner_closed_i (inner_closed_i),
    .outer_closed_i (outer_closed_i),
    .press_done_i   (press_done_i),
    .evac_done_i    (evac_done_i),
    .fault_clr_i    (fault_clr_i),
    .press_start_o  (press_start_o),
    .evac_start_o   (evac_start_o),
    .inner_unlock_o (inner_unlock_o),
    .outer_unlock_o (outer_unlock_o),
    .busy_o         (busy_o),
    .fault_o        (fault_o),
    .state_o        (state_o)
  );

  always #5 clk = ~clk;

  // Drive inputs at the falling edge, clock once, sample 1 ns after the edge.
  task automatic apply(input logic [7:0] in, input logic [8:0] exp, input string name);
    logic [8:0] act;
    @(negedge clk);
    {rst_i, inner_req_i, outer_req_i, inner_closed_i, outer_closed_i,
     press_done_i, evac_done_i, fault_clr_i} = in;
    @(posedge clk);
    #1;
    act = {state_o, press_start_o, evac_start_o, inner_unlock_o, outer_unlock_o,
           busy_o, fault_o};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got state=%0d ps/es/iu/ou/busy/flt=%b, want state=%0d %b",
               name, act[8:6], act[5:0], exp[8:6], exp[5:0]);
    end
  endtask

  vec_t tbl [16];

  initial begin
    {rst_i, inner_req_i, outer_req_i, inner_closed_i, outer_closed_i,
     press_done_i, evac_done_i, fault_clr_i} = I_RST;

    // Main flow: reset, evacuate with a stray press_done, open-door blocked
    // request in VAC, repressurize, ignored requests in destination states.
    tbl[0]  = '{I_RST,     E_PRESS};
    tbl[1]  = '{I_OREQ,    E_EVW_S};
    tbl[2]  = '{I_IDLE,    E_EVW};
    tbl[3]  = '{I_PD,      E_EVW};
    tbl[4]  = '{I_IDLE,    E_EVW};
    tbl[5]  = '{I_IDLE,    E_EVW};
    tbl[6]  = '{I_IDLE,    E_EVW};
    tbl[7]  = '{I_IDLE,    E_EVW};
    tbl[8]  = '{I_ED,      E_VAC};
    tbl[9]  = '{I_OREQ,    E_VAC};
    tbl[10] = '{I_IREQ_OO, E_VAC};
    tbl[11] = '{I_IREQ_OO, E_VAC};
    tbl[12] = '{I_IREQ,    E_PRW_S};
    tbl[13] = '{I_IREQ,    E_PRW};
    tbl[14] = '{I_PD,      E_PRESS};
    tbl[15] = '{I_IREQ,    E_PRESS};

    for (int i = 0; i < 16; i++) apply(tbl[i].in, tbl[i].exp, $sformatf("tbl%0d", i));

    // Watchdog: no done for TIMEOUT wait cycles -> FAULT on the last one.
    apply(I_OREQ, E_EVW_S, "to_entry");
    for (int k = 1; k < TIMEOUT; k++) apply(I_IDLE, E_EVW, $sformatf("to_wait%0d", k));
    apply(I_IDLE,   E_FLT,   "to_fault");
    apply(I_CLR_OO, E_FLT,   "clr_door_open");
    apply(I_PD,     E_FLT,   "fault_ignores_done");
    apply(I_CLR,    E_PRW_S, "clr_start");
    apply(I_IDLE,   E_PRW,   "clr_wait");
    apply(I_PD,     E_PRESS, "clr_done");

    // Done in the last permitted cycle still completes normally.
    apply(I_OREQ, E_EVW_S, "edge_entry");
    for (int k = 1; k < TIMEOUT; k++) apply(I_IDLE, E_EVW, $sformatf("edge_wait%0d", k));
    apply(I_ED, E_VAC, "edge_done");

    // Door opens in PRESS_WAIT cycle 3; the late press_done is ignored.
    apply(I_IREQ,    E_PRW_S, "dr_entry");
    apply(I_IDLE,    E_PRW,   "dr_c1");
    apply(I_IDLE,    E_PRW,   "dr_c2");
    apply(I_IC_OPEN, E_FLT,   "dr_open");
    apply(I_PD,      E_FLT,   "dr_late_done");
    apply(I_CLR,     E_PRW_S, "dr_clr");
    apply(I_PD,      E_PRESS, "dr_done");

    // Reset in EVAC_WAIT cycle 4 returns to PRESS with no start pulse.
    apply(I_OREQ,   E_EVW_S, "rst_entry");
    apply(I_IDLE,   E_EVW,   "rst_c1");
    apply(I_IDLE,   E_EVW,   "rst_c2");
    apply(I_IDLE,   E_EVW,   "rst_c3");
    apply(I_RST_ED, E_PRESS, "rst_mid");
    apply(I_IDLE,   E_PRESS, "rst_after");

    // Done together with a door opening -> FAULT.
    apply(I_OREQ,  E_EVW_S, "dd_entry");
    apply(I_ED_OO, E_FLT,   "dd_fault");
    apply(I_CLR,   E_PRW_S, "dd_clr");
    apply(I_PD,    E_PRESS, "dd_done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
